mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares port B of the dual-port `Memory` between the CPU load/store path (requester 0) and a second bus master (requester 1, e.g. the I/O/DMA engine). Port A stays dedicated to instruction fetch and is not touched by this block. It accepts single-word read/write requests over a req/gnt handshake, drives the memory port from registers, and returns read data with a valid strobe to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 15, memory word-address width (matches `Memory` port address)
- `DATA_W`, 16, data word width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `r0_req`, `r1_req`  in  1  request; held high with addr/we/wdata stable until matching gnt seen
- `r0_addr`, `r1_addr`  in  ADDR_W  word address
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data
- `r0_gnt`, `r1_gnt`  out  1  one-cycle pulse: request accepted and issued to memory this cycle
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle pulse: read data valid on `rX_rdata`
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data (both driven from `mem_dout`; meaningful only with rvalid)
- `mem_addr`  out  ADDR_W  to `Memory` port_b_address (registered)
- `mem_din`  out  DATA_W  to port_b_in (registered)
- `mem_we`  out  1  to port_b_we (registered)
- `mem_dout`  in  DATA_W  from port_b_out (synchronous read, 1-cycle latency)

## Operation
- Issue register stage holds {valid, owner, addr, we, wdata}; read-return stage holds {valid, owner}.
- Each rising edge: eligible requesters = those with req high AND gnt not high this cycle (a requester is never granted on the cycle after its own grant, even if req stays high).
- Arbitration among eligible: fixed priority, requester 0 wins (round-robin when configured, see Configuration).
- Winner captured: issue stage loads winner's addr/we/wdata; `rX_gnt` of winner = 1 for that next cycle; `mem_addr/mem_din/mem_we` reflect the captured request during that cycle.
- No eligible requester: issue valid = 0, `mem_we` = 0, `mem_addr`/`mem_din` hold last value.
- Read issued (we = 0): read-return stage loads {1, owner}; next cycle `rX_rvalid` of owner = 1. Writes produce no rvalid.
- Requester may present a new transaction (new addr/we/wdata) the cycle after its gnt; it must be stable before the following edge.
- `mem_we` is never high outside a granted write cycle.

## Timing
- Cycle T: `rX_req` = 1 sampled. Cycle T+1: `rX_gnt` = 1, memory port driven, memory samples at end of T+1. Cycle T+2: `rX_rvalid` = 1 (reads), `rX_rdata` = memory word.
- Request-to-grant latency 1 cycle when uncontended; read latency 2 cycles from req.
- Per-requester max rate: one grant every 2 cycles; port B can be busy every cycle when both requesters alternate.
- Contention loser keeps req high and is granted no earlier than the cycle after the winner's gnt.
- Reset (async, low): all gnt, rvalid, `mem_we` = 0; `mem_addr` = 0, `mem_din` = 0; issue/return stages invalid; RR pointer = favor requester 0. Reset mid-transaction: pending rvalid is dropped, in-flight write cycle aborted (mem_we drops asynchronously). First grant possible in the cycle after the first edge following reset release.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. One-bit `last` pointer updated to each winner; when both eligible, the requester not equal to `last` wins. Reset value of `last` = 1 (requester 0 wins first tie).
- Not defined: strict fixed priority, requester 0 always wins ties; requester 1 can starve if requester 0 is eligible every cycle.

## Test plan
- Single read: preload mem[0x0010] = 0xBEEF; r0 read addr 0x0010 at T -> r0_gnt at T+1, r0_rvalid at T+2 with r0_rdata = 0xBEEF; r1 outputs stay 0.
- Write then read: r1 writes 0x1234 to 0x7FFF (top address) -> r1_gnt, mem_we = 1 for one cycle, no rvalid; subsequent r1 read of 0x7FFF returns 0x1234.
- Simultaneous requests, fixed priority (macro off): both req at T -> r0_gnt at T+1, r1_gnt at T+2; with r0 req held continuously, r0 granted T+1, T+3, ... and r1 only in the gaps T+2, T+4.
- Simultaneous requests, round-robin (`MEM_ARB_RR_EN`): both held high for 8 cycles -> grants alternate r0, r1, r0, r1 ... with exactly one gnt per cycle, 4 each.
- Back-to-back: r0 holds req, new addr each cycle after gnt (reads of 0x0000, 0x0001, 0x0002) -> gnt every 2nd cycle, rvalid data in address order.
- Reset mid-read: assert reset low in the cycle r0_gnt is high -> r0_gnt, r0_rvalid, mem_we = 0 immediately, no rvalid after release; a fresh request after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus memory port B bundle.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              r0_req,    r1_req;
  logic [ADDR_W-1:0] r0_addr,   r1_addr;
  logic              r0_we,     r1_we;
  logic [DATA_W-1:0] r0_wdata,  r1_wdata;
  logic              r0_gnt,    r1_gnt;
  logic              r0_rvalid, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata,  r1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  r0_req, r1_req, r0_addr, r1_addr, r0_we, r1_we, r0_wdata, r1_wdata,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
    output mem_addr, mem_din, mem_we,
    input  mem_dout
  );

  modport master (
    output r0_req, r1_req, r0_addr, r1_addr, r0_we, r1_we, r0_wdata, r1_wdata,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
    input  mem_addr, mem_din, mem_we,
    output mem_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares memory port B between two single-word requesters.
// Issue stage (vld_pipe[0]) drives the memory port from flops; return stage
// (vld_pipe[1]) flags the read data that appears one cycle later.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed
// priority to requester 0.
module mem_port_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int NREQ = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [NREQ-1:0] req;
  req_t [NREQ-1:0] req_pl;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] elig;
  logic            win;

  // [0] issue valid, [1] read-return valid; owner bit travels alongside
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic [1:0]        own_pipe_q, own_pipe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  assign req = {bus.r1_req, bus.r0_req};
  assign req_pl[0].addr  = bus.r0_addr;
  assign req_pl[0].we    = bus.r0_we;
  assign req_pl[0].wdata = bus.r0_wdata;
  assign req_pl[1].addr  = bus.r1_addr;
  assign req_pl[1].we    = bus.r1_we;
  assign req_pl[1].wdata = bus.r1_wdata;

  // grants are decoded straight from the issue stage so they are glitch-free
  assign gnt[0] = vld_pipe_q[0] & ~own_pipe_q[0];
  assign gnt[1] = vld_pipe_q[0] &  own_pipe_q[0];

  assign bus.r0_gnt    = gnt[0];
  assign bus.r1_gnt    = gnt[1];
  assign bus.r0_rvalid = vld_pipe_q[1] & ~own_pipe_q[1];
  assign bus.r1_rvalid = vld_pipe_q[1] &  own_pipe_q[1];
  assign bus.r0_rdata  = bus.mem_dout;
  assign bus.r1_rdata  = bus.mem_dout;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.mem_we    = we_q;

  // pick a winner among requesters not already granted this cycle
  always_comb begin
    elig = req & ~gnt;
    win  = 1'b0;
    unique case (elig)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
`ifdef MEM_ARB_RR_EN
      2'b11:   win = ~last_q;
`else
      2'b11:   win = 1'b0;
`endif
      default: win = 1'b0;
    endcase
  end

  // next state for issue/return stages; port addr/data hold when idle
  always_comb begin
    vld_pipe_d[0] = |elig;
    own_pipe_d[0] = win;
    vld_pipe_d[1] = vld_pipe_q[0] & ~we_q;
    own_pipe_d[1] = own_pipe_q[0];
    addr_d        = addr_q;
    din_d         = din_q;
    we_d          = 1'b0;
    if (|elig) begin
      addr_d = req_pl[win].addr;
      din_d  = req_pl[win].wdata;
      we_d   = req_pl[win].we;
    end
  end

`ifdef MEM_ARB_RR_EN
  // remember the most recent winner for the next tie
  always_comb begin
    last_d = last_q;
    if (|elig) last_d = win;
  end

  // round-robin pointer; reset favors requester 0 on the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // pipeline and port registers; reset aborts anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      own_pipe_q <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      own_pipe_q <= own_pipe_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; expected read data is queued per
// requester when a read is issued and popped when rvalid appears.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory port B model: synchronous read, one-cycle latency
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  // scoreboard: pop expected data on every rvalid; global port sanity
  always @(negedge clk) begin
    if (bus.r0_rvalid) begin
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL r0_rvalid_unexpected got 1 exp 0");
      end else begin
        logic [DATA_W-1:0] e;
        e = q0.pop_front();
        if (bus.r0_rdata !== e) begin
          errors++; $display("FAIL r0_rdata got %h exp %h", bus.r0_rdata, e);
        end
      end
    end
    if (bus.r1_rvalid) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL r1_rvalid_unexpected got 1 exp 0");
      end else begin
        logic [DATA_W-1:0] e;
        e = q1.pop_front();
        if (bus.r1_rdata !== e) begin
          errors++; $display("FAIL r1_rdata got %h exp %h", bus.r1_rdata, e);
        end
      end
    end
    if (bus.r0_gnt || bus.r1_gnt || bus.mem_we) begin
      checks++;
      if ((bus.r0_gnt && bus.r1_gnt) || (bus.mem_we && !(bus.r0_gnt || bus.r1_gnt))) begin
        errors++;
        $display("FAIL port_excl got gnt=%b%b we=%b exp one gnt, we only with gnt",
                 bus.r1_gnt, bus.r0_gnt, bus.mem_we);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); endtask

  function automatic logic gnt_of(input int idx);
    return (idx != 0) ? bus.r1_gnt : bus.r0_gnt;
  endfunction

  function automatic logic rv_of(input int idx);
    return (idx != 0) ? bus.r1_rvalid : bus.r0_rvalid;
  endfunction

  task automatic set_req(input int idx, input logic rq, input logic [ADDR_W-1:0] a,
                         input logic we, input logic [DATA_W-1:0] d);
    if (idx == 0) begin
      bus.r0_req = rq; bus.r0_addr = a; bus.r0_we = we; bus.r0_wdata = d;
    end else begin
      bus.r1_req = rq; bus.r1_addr = a; bus.r1_we = we; bus.r1_wdata = d;
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem[a] = d; ref_mem[a] = d;
  endtask

  // drive a request and record its expected effect
  task automatic issue(input int idx, input logic [ADDR_W-1:0] a, input logic we,
                       input logic [DATA_W-1:0] d);
    set_req(idx, 1'b1, a, we, d);
    if (we) ref_mem[a] = d;
    else if (idx == 0) q0.push_back(ref_mem[a]);
    else q1.push_back(ref_mem[a]);
  endtask

  task automatic apply_reset();
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // one uncontended transaction with full cycle-by-cycle timing checks
  task automatic run_single(input int idx, input logic [ADDR_W-1:0] a, input logic we,
                            input logic [DATA_W-1:0] d);
    tick(); issue(idx, a, we, d);
    smp();
    checks++;
    if (gnt_of(idx) !== 1'b0) begin errors++; $display("FAIL gnt_early r%0d got %b exp 0", idx, gnt_of(idx)); end
    tick(); smp();
    checks++;
    if (gnt_of(idx) !== 1'b1 || gnt_of(1-idx) !== 1'b0) begin
      errors++; $display("FAIL gnt_t1 r%0d got %b/%b exp 1/0", idx, gnt_of(idx), gnt_of(1-idx));
    end
    checks++;
    if (bus.mem_addr !== a || bus.mem_we !== we || (we && bus.mem_din !== d)) begin
      errors++; $display("FAIL port_t1 got a=%h we=%b d=%h exp a=%h we=%b d=%h",
                         bus.mem_addr, bus.mem_we, bus.mem_din, a, we, d);
    end
    tick(); set_req(idx, 1'b0, a, we, d); smp();
    checks++;
    if (gnt_of(idx) !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL gnt_t2 r%0d got gnt=%b we=%b exp 0/0", idx, gnt_of(idx), bus.mem_we);
    end
    checks++;
    if (rv_of(idx) !== !we || rv_of(1-idx) !== 1'b0) begin
      errors++; $display("FAIL rvalid_t2 r%0d got %b/%b exp %b/0", idx, rv_of(idx), rv_of(1-idx), !we);
    end
    checks++;
    if (bus.mem_addr !== a || (we && bus.mem_din !== d)) begin
      errors++; $display("FAIL port_hold got a=%h d=%h exp a=%h", bus.mem_addr, bus.mem_din, a);
    end
    tick(); smp();
    checks++;
    if (rv_of(idx) !== 1'b0) begin errors++; $display("FAIL rvalid_t3 r%0d got 1 exp 0", idx); end
  endtask

  task automatic test_reset();
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    tick(); tick(); smp();
    checks++;
    if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 00000",
                         {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_din !== '0) begin
      errors++; $display("FAIL reset_port got a=%h d=%h exp 0/0", bus.mem_addr, bus.mem_din);
    end
    tick(); reset = 1'b1;
  endtask

  task automatic test_single_read();
    preload(15'h0010, 16'hBEEF);
    run_single(0, 15'h0010, 1'b0, '0);
  endtask

  task automatic test_write_read();
    preload(15'h7FFF, 16'h0000);
    run_single(1, 15'h7FFF, 1'b1, 16'h1234);
    run_single(1, 15'h7FFF, 1'b0, '0);
  endtask

  task automatic test_contention();
    int n0, n1;
    logic e0, first;
    n0 = 0; n1 = 0;
    apply_reset();
    preload(15'h0020, 16'hA5A5);
    preload(15'h0021, 16'h5A5A);
    tick();
    set_req(0, 1'b1, 15'h0020, 1'b0, '0);
    set_req(1, 1'b1, 15'h0021, 1'b0, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        set_req(0, 1'b0, 15'h0020, 1'b0, '0);
        set_req(1, 1'b0, 15'h0021, 1'b0, '0);
      end
      e0 = (k % 2) == 1;
      if (e0) q0.push_back(ref_mem[15'h0020]); else q1.push_back(ref_mem[15'h0021]);
      smp();
      if (bus.r0_gnt) n0++;
      if (bus.r1_gnt) n1++;
      checks++;
      if (bus.r0_gnt !== e0 || bus.r1_gnt !== !e0) begin
        errors++; $display("FAIL contend_c%0d got r0=%b r1=%b exp r0=%b r1=%b",
                           k, bus.r0_gnt, bus.r1_gnt, e0, !e0);
      end
    end
    checks++;
    if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL contend_count got %0d/%0d exp 4/4", n0, n1); end
    tick(); smp();
    checks++;
    if (bus.r0_gnt || bus.r1_gnt) begin errors++; $display("FAIL contend_idle got gnt exp none"); end
    tick(); tick();
    // tie after r0 won last: round-robin favors r1, fixed priority keeps r0
    run_single(0, 15'h0020, 1'b0, '0);
`ifdef MEM_ARB_RR_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    tick();
    issue(0, 15'h0020, 1'b0, '0);
    issue(1, 15'h0021, 1'b0, '0);
    tick(); smp();
    checks++;
    if (gnt_of(first) !== 1'b1 || gnt_of(1 - first) !== 1'b0) begin
      errors++; $display("FAIL tie_first got r0=%b r1=%b exp winner r%0d", bus.r0_gnt, bus.r1_gnt, first);
    end
    tick(); set_req(first, 1'b0, '0, 1'b0, '0); smp();
    checks++;
    if (gnt_of(1 - first) !== 1'b1 || gnt_of(first) !== 1'b0) begin
      errors++; $display("FAIL tie_second got r0=%b r1=%b exp winner r%0d", bus.r0_gnt, bus.r1_gnt, 1 - first);
    end
    tick(); set_req(1 - first, 1'b0, '0, 1'b0, '0);
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    preload(15'h0000, 16'h1111);
    preload(15'h0001, 16'h2222);
    preload(15'h0002, 16'h3333);
    tick(); issue(0, 15'h0000, 1'b0, '0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) issue(0, 15'h0001, 1'b0, '0);
      if (k == 4) issue(0, 15'h0002, 1'b0, '0);
      if (k == 6) set_req(0, 1'b0, '0, 1'b0, '0);
      smp();
      checks++;
      if (bus.r0_gnt !== ((k % 2) == 1)) begin
        errors++; $display("FAIL b2b_gnt_c%0d got %b exp %b", k, bus.r0_gnt, (k % 2) == 1);
      end
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    tick(); issue(0, 15'h0010, 1'b0, '0);
    tick();
    checks++;
    if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", bus.r0_gnt); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.r0_gnt !== 1'b0 || bus.r0_rvalid !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL rstmid_async got gnt=%b rv=%b we=%b a=%h exp 0",
                         bus.r0_gnt, bus.r0_rvalid, bus.mem_we, bus.mem_addr);
    end
    q0.delete();
    set_req(0, 1'b0, '0, 1'b0, '0);
    tick(); tick(); reset = 1'b1;
    tick(); tick();
    // aborted write must never reach memory
    preload(15'h0030, 16'h0BAD);
    tick(); issue(1, 15'h0030, 1'b1, 16'hCAFE);
    tick();
    checks++;
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rstwr_we got %b exp 1", bus.mem_we); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.r1_gnt !== 1'b0) begin
      errors++; $display("FAIL rstwr_async got we=%b gnt=%b exp 0/0", bus.mem_we, bus.r1_gnt);
    end
    ref_mem[15'h0030] = 16'h0BAD;
    set_req(1, 1'b0, '0, 1'b0, '0);
    tick(); tick(); reset = 1'b1;
    run_single(0, 15'h0010, 1'b0, '0);
    run_single(1, 15'h0030, 1'b0, '0);
  endtask

  initial begin
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL missing_rvalid got %0d/%0d pending exp 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
